// File: rtl/output_sram_wr_arbiter.sv
// Round-robin responder for bank write-back streams into the Output SRAM.
// One bank is granted at a time; its sos/eos beat stream is written at nodeid*BEATS_PER_NODE + beat_idx.
module output_sram_wr_arbiter #(
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned FV_SIZE     = 16,
  parameter int unsigned MAX_FV_NUM  = 8,
  parameter int unsigned MAX_NODE_ID = 256,
  parameter int unsigned TIMEOUT     = 15,
  localparam int unsigned BEATS_PER_NODE = MAX_FV_NUM / 2,
  localparam int unsigned NODE_W         = $clog2(MAX_NODE_ID),
  localparam int unsigned ADDR_W         = $clog2(MAX_NODE_ID * BEATS_PER_NODE),
  localparam int unsigned DATA_W         = 2 * FV_SIZE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BANKS-1:0]          bank_req,
  input  logic [NUM_BANKS-1:0]          bank_valid,
  input  logic [NUM_BANKS-1:0]          bank_sos,
  input  logic [NUM_BANKS-1:0]          bank_eos,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_data,
  input  logic [NUM_BANKS*NODE_W-1:0]   bank_nodeid,
  output logic [NUM_BANKS-1:0]          grant,
  output logic                          sram_wen,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  output logic                          wr_done,
  output logic [NODE_W-1:0]             wr_nodeid,
  output logic                          err_timeout,
  output logic                          err_overflow
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned BI_W   = $clog2(BEATS_PER_NODE + 1);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOS = 2'd1,
    STREAM   = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e               state_q,        state_d;
  logic [NUM_BANKS-1:0] grant_q,        grant_d;
  logic [BANK_W-1:0]    gidx_q,         gidx_d;
  logic [BANK_W-1:0]    rr_ptr_q,       rr_ptr_d;
  logic [CNT_W-1:0]     idle_cnt_q,     idle_cnt_d;
  logic [BI_W-1:0]      beat_idx_q,     beat_idx_d;
  logic [ADDR_W-1:0]    base_q,         base_d;
  logic [NODE_W-1:0]    nodeid_q,       nodeid_d;
  logic                 ovf_seen_q,     ovf_seen_d;
  logic                 sram_wen_q,     sram_wen_d;
  logic [ADDR_W-1:0]    sram_addr_q,    sram_addr_d;
  logic [DATA_W-1:0]    sram_wdata_q,   sram_wdata_d;
  logic                 wr_done_q,      wr_done_d;
  logic [NODE_W-1:0]    wr_nodeid_q,    wr_nodeid_d;
  logic                 err_timeout_q,  err_timeout_d;
  logic                 err_overflow_q, err_overflow_d;

  logic                 req_found;
  logic [BANK_W-1:0]    pick_idx;
  logic [BANK_W-1:0]    cand;
  logic                 sel_valid, sel_sos, sel_eos;
  logic [DATA_W-1:0]    sel_data;
  logic [NODE_W-1:0]    sel_nodeid;
  logic                 timeout_hit;
  logic [ADDR_W-1:0]    sos_base;

  // First requester at or after rr_ptr, scanning cyclically.
  always_comb begin
    req_found = 1'b0;
    pick_idx  = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      cand = BANK_W'((32'(rr_ptr_q) + i) % NUM_BANKS);
      if (!req_found && bank_req[cand]) begin
        req_found = 1'b1;
        pick_idx  = cand;
      end
    end
  end

  always_comb begin
    sel_valid  = 1'b0;
    sel_sos    = 1'b0;
    sel_eos    = 1'b0;
    sel_data   = '0;
    sel_nodeid = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (gidx_q == BANK_W'(b)) begin
        sel_valid  = bank_valid[b];
        sel_sos    = bank_sos[b];
        sel_eos    = bank_eos[b];
        sel_data   = bank_data[b*DATA_W +: DATA_W];
        sel_nodeid = bank_nodeid[b*NODE_W +: NODE_W];
      end
    end
  end

  assign timeout_hit = (idle_cnt_q == CNT_W'(TIMEOUT - 1));
  assign sos_base    = ADDR_W'(sel_nodeid) * ADDR_W'(BEATS_PER_NODE);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    rr_ptr_d       = rr_ptr_q;
    idle_cnt_d     = idle_cnt_q;
    beat_idx_d     = beat_idx_q;
    base_d         = base_q;
    nodeid_d       = nodeid_q;
    ovf_seen_d     = ovf_seen_q;
    sram_wen_d     = 1'b0;
    sram_addr_d    = sram_addr_q;
    sram_wdata_d   = sram_wdata_q;
    wr_done_d      = 1'b0;
    wr_nodeid_d    = wr_nodeid_q;
    err_timeout_d  = 1'b0;
    err_overflow_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_d    = NUM_BANKS'(1) << pick_idx;
          gidx_d     = pick_idx;
          idle_cnt_d = '0;
          ovf_seen_d = 1'b0;
          state_d    = WAIT_SOS;
        end
      end
      WAIT_SOS: begin
        if (sel_valid && sel_sos) begin
          nodeid_d     = sel_nodeid;
          base_d       = sos_base;
          sram_wen_d   = 1'b1;
          sram_addr_d  = sos_base;
          sram_wdata_d = sel_data;
          beat_idx_d   = BI_W'(1);
          idle_cnt_d   = '0;
          if (sel_eos) begin
            grant_d = '0;
            state_d = DONE;
          end else begin
            state_d = STREAM;
          end
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
          grant_d       = '0;
          state_d       = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      STREAM: begin
        if (sel_valid) begin
          idle_cnt_d = '0;
          if (beat_idx_q < BI_W'(BEATS_PER_NODE)) begin
            sram_wen_d   = 1'b1;
            sram_addr_d  = base_q + ADDR_W'(beat_idx_q);
            sram_wdata_d = sel_data;
            beat_idx_d   = beat_idx_q + 1'b1;
          end else if (!ovf_seen_q) begin
            err_overflow_d = 1'b1;
            ovf_seen_d     = 1'b1;
          end
          if (sel_eos) begin
            grant_d = '0;
            state_d = DONE;
          end
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
          grant_d       = '0;
          state_d       = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      DONE: begin
        wr_done_d   = 1'b1;
        wr_nodeid_d = nodeid_q;
        rr_ptr_d    = (gidx_q == BANK_W'(NUM_BANKS - 1)) ? '0 : gidx_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      gidx_q         <= '0;
      rr_ptr_q       <= '0;
      idle_cnt_q     <= '0;
      beat_idx_q     <= '0;
      base_q         <= '0;
      nodeid_q       <= '0;
      ovf_seen_q     <= 1'b0;
      sram_wen_q     <= 1'b0;
      sram_addr_q    <= '0;
      sram_wdata_q   <= '0;
      wr_done_q      <= 1'b0;
      wr_nodeid_q    <= '0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      gidx_q         <= gidx_d;
      rr_ptr_q       <= rr_ptr_d;
      idle_cnt_q     <= idle_cnt_d;
      beat_idx_q     <= beat_idx_d;
      base_q         <= base_d;
      nodeid_q       <= nodeid_d;
      ovf_seen_q     <= ovf_seen_d;
      sram_wen_q     <= sram_wen_d;
      sram_addr_q    <= sram_addr_d;
      sram_wdata_q   <= sram_wdata_d;
      wr_done_q      <= wr_done_d;
      wr_nodeid_q    <= wr_nodeid_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign grant        = grant_q;
  assign sram_wen     = sram_wen_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;
  assign wr_done      = wr_done_q;
  assign wr_nodeid    = wr_nodeid_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;

endmodule
